// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt source for the PC.
// Dispatches one request at a time and tracks the fixed-length ISR by counting exec2 pulses.
module interrupt_controller #(
  parameter int               N_IRQ      = 8,
  parameter int               ISR_LEN    = 10,
  parameter logic [N_IRQ-1:0] MASK_RESET = {N_IRQ{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IRQ-1:0]         irq_in,
  input  logic                     mask_we,
  input  logic [N_IRQ-1:0]         mask_data,
  input  logic                     exec2,
  input  logic                     pc_halt,
  output logic                     interrupt_signal,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic                     in_service,
  output logic [N_IRQ-1:0]         pending
);

  localparam int               IDW      = $clog2(N_IRQ);
  localparam int               CW       = $clog2(ISR_LEN + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(ISR_LEN - 1);
  localparam logic [N_IRQ-1:0] ONE      = N_IRQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_REQUEST,
    S_SERVICE
  } state_t;

  state_t           r_state;
  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_irq_id;
  logic             r_in_service;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_reset_bit;
  logic [IDW-1:0]   w_win_id;
  logic             w_any;
  logic             w_dispatch;
  logic             w_abort;

  assign w_edge = irq_in & ~r_irq_prev;
  assign w_elig = r_pending & r_mask;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    w_win_id = '0;
    w_any    = 1'b0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (w_elig[i-1]) begin
        w_any    = 1'b1;
        w_win_id = IDW'(i - 1);
      end
    end
  end

  assign w_dispatch  = (r_state == S_IDLE) && w_any && !pc_halt;
  assign w_abort     = ((r_state == S_ARM) || (r_state == S_REQUEST)) && pc_halt;
  assign w_clr       = w_dispatch ? (ONE << w_win_id) : '0;
  assign w_reset_bit = w_abort ? (ONE << r_irq_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= MASK_RESET;
    end else begin
      r_irq_prev <= irq_in;
      // New edges are OR-ed in after the clear so a same-cycle edge on the winner keeps it pending.
      r_pending  <= (r_pending & ~w_clr) | w_edge | w_reset_bit;
      if (mask_we) begin
        r_mask <= mask_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_irq_id     <= '0;
      r_cnt        <= '0;
      r_in_service <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_state  <= S_ARM;
            r_irq_id <= w_win_id;
          end
        end
        S_ARM: begin
          r_state <= pc_halt ? S_IDLE : S_REQUEST;
        end
        S_REQUEST: begin
          if (pc_halt) begin
            r_state <= S_IDLE;
          end else if (exec2) begin
            r_state      <= S_SERVICE;
            r_cnt        <= '0;
            r_in_service <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (exec2) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) begin
              r_state      <= S_IDLE;
              r_in_service <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign interrupt_signal = !pc_halt &&
                            ((r_state == S_ARM) || ((r_state == S_REQUEST) && !exec2));
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: a scoreboard of expected dispatch ids checked at each ISR entry,
// a vector table of request/mask patterns, and hand sequences for latency, halt and reset cases.
module tb_interrupt_controller;

  localparam int ISR_LEN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_data = '0;
  logic       exec2 = 1'b0;
  logic       pc_halt = 1'b0;
  logic       interrupt_signal;
  logic [2:0] irq_id;
  logic       in_service;
  logic [7:0] pending;

  interrupt_controller #(.N_IRQ(8), .ISR_LEN(ISR_LEN), .MASK_RESET(8'hFF)) dut (
    .clk(clk), .reset(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_data(mask_data),
    .exec2(exec2), .pc_halt(pc_halt), .interrupt_signal(interrupt_signal),
    .irq_id(irq_id), .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         e2_auto = 1'b1;
  logic [2:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (e2_auto) exec2 = (cyc % 4 == 0);
  endtask

  task automatic write_mask(input logic [7:0] m);
    tick();
    mask_we   = 1'b1;
    mask_data = m;
    tick();
    mask_we   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input bit chkb);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      @(negedge clk);
      if (chkb && in_service && irq_id == 3'd1) check("b_pending_in_isr", pending, 8'h04);
      if (exp_q.size() == 0 && !in_service && !interrupt_signal) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy expected idle, %0d takes outstanding", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: each ISR entry pops the next expected id; each ISR must span ISR_LEN exec2 pulses.
  bit prev_is = 1'b0;
  int e2cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_is = 1'b0;
      e2cnt   = 0;
    end else begin
      if (in_service && !prev_is) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL take_unexpected: got irq_id %0d expected no take", irq_id);
        end else begin
          check("take_id", {29'd0, irq_id}, {29'd0, exp_q.pop_front()});
        end
        e2cnt = 0;
      end
      if (in_service && exec2) e2cnt++;
      if (!in_service && prev_is) check("isr_len", e2cnt, ISR_LEN);
      prev_is = in_service;
    end
  end

  typedef struct {
    logic [7:0]  irq;
    logic [7:0]  mask;
    int          n1;
    int          n2;
    logic [31:0] ids;        // nibble k = k-th expected take (first n1 under mask, then n2 after unmask)
    logic [7:0]  pend_held;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{irq: 8'h04, mask: 8'hFF, n1: 1, n2: 0, ids: 32'h0000_0002, pend_held: 8'h00};
    vecs[1] = '{irq: 8'h81, mask: 8'hFF, n1: 2, n2: 0, ids: 32'h0000_0070, pend_held: 8'h00};
    vecs[2] = '{irq: 8'hF0, mask: 8'h5F, n1: 2, n2: 2, ids: 32'h0000_7564, pend_held: 8'hA0};
    vecs[3] = '{irq: 8'h3C, mask: 8'h0F, n1: 2, n2: 2, ids: 32'h0000_5432, pend_held: 8'h30};
    vecs[4] = '{irq: 8'hFF, mask: 8'h00, n1: 0, n2: 8, ids: 32'h7654_3210, pend_held: 8'hFF};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_intr", interrupt_signal, 1'b0);
    check("rst_in_service", in_service, 1'b0);
    check("rst_irq_id", irq_id, 3'd0);
    check("rst_pending", pending, 8'h00);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // A: single request latency
    tick();
    irq_in = 8'h04;
    exp_q.push_back(3'd2);
    @(negedge clk);
    check("a_pending_t", pending, 8'h00);
    tick();
    irq_in = 8'h00;
    @(negedge clk);
    check("a_pending_t1", pending, 8'h04);
    check("a_intr_t1", interrupt_signal, 1'b0);
    tick();
    @(negedge clk);
    check("a_intr_arm", interrupt_signal, 1'b1);
    check("a_id_arm", irq_id, 3'd2);
    check("a_pending_arm", pending, 8'h00);
    wait_idle("a", 1'b0);

    // B: simultaneous edges, priority order
    tick();
    irq_in = 8'h06;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    tick();
    irq_in = 8'h00;
    wait_idle("b", 1'b1);

    // C: masked pending line held, dispatched two cycles after unmask
    write_mask(8'hFE);
    tick();
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("c_intr_masked", interrupt_signal, 1'b0);
      check("c_pending_held", pending, 8'h01);
    end
    tick();
    mask_we   = 1'b1;
    mask_data = 8'hFF;
    exp_q.push_back(3'd0);
    tick();
    mask_we = 1'b0;
    @(negedge clk);
    check("c_intr_w1", interrupt_signal, 1'b0);
    tick();
    @(negedge clk);
    check("c_intr_w2", interrupt_signal, 1'b1);
    check("c_id_w2", irq_id, 3'd0);
    wait_idle("c", 1'b0);

    // D: halt during REQUEST aborts and re-pends
    e2_auto = 1'b0;
    exec2   = 1'b0;
    tick();
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check("d_intr_req", interrupt_signal, 1'b1);
    tick();
    pc_halt = 1'b1;
    #1;
    check("d_intr_halt_same", interrupt_signal, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check("d_intr_halted", interrupt_signal, 1'b0);
      check("d_pending_reset", pending, 8'h10);
    end
    tick();
    pc_halt = 1'b0;
    exp_q.push_back(3'd4);
    tick();
    @(negedge clk);
    check("d_intr_rearm", interrupt_signal, 1'b1);
    check("d_id_rearm", irq_id, 3'd4);
    e2_auto = 1'b1;
    wait_idle("d", 1'b0);

    // E: exec2 in ARM is not the take
    e2_auto = 1'b0;
    exec2   = 1'b0;
    tick();
    irq_in = 8'h02;
    exp_q.push_back(3'd1);
    tick();
    irq_in = 8'h00;
    tick();
    exec2 = 1'b1;
    @(negedge clk);
    check("e_intr_arm_e2", interrupt_signal, 1'b1);
    tick();
    exec2 = 1'b0;
    @(negedge clk);
    check("e_intr_req", interrupt_signal, 1'b1);
    check("e_is_req", in_service, 1'b0);
    tick();
    exec2 = 1'b1;
    @(negedge clk);
    check("e_intr_take", interrupt_signal, 1'b0);
    check("e_is_take", in_service, 1'b0);
    tick();
    exec2 = 1'b0;
    @(negedge clk);
    check("e_is_entered", in_service, 1'b1);
    for (int k = 0; k < ISR_LEN; k++) begin
      tick();
      exec2 = 1'b1;
      @(negedge clk);
      check("e_is_during", in_service, 1'b1);
      tick();
      exec2 = 1'b0;
    end
    @(negedge clk);
    check("e_is_done", in_service, 1'b0);
    e2_auto = 1'b1;
    wait_idle("e", 1'b0);

    // G: edge on the winner in its dispatch cycle keeps it pending
    e2_auto = 1'b0;
    exec2   = 1'b0;
    tick();
    pc_halt = 1'b1;
    irq_in  = 8'h20;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check("g_intr_halted", interrupt_signal, 1'b0);
    check("g_pending", pending, 8'h20);
    tick();
    pc_halt = 1'b0;
    irq_in  = 8'h20;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd5);
    tick();
    irq_in = 8'h00;
    @(negedge clk);
    check("g_intr_arm", interrupt_signal, 1'b1);
    check("g_pending_setwins", pending, 8'h20);
    e2_auto = 1'b1;
    wait_idle("g", 1'b0);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      logic [31:0] sh;
      write_mask(vecs[v].mask);
      for (int k = 0; k < vecs[v].n1; k++) begin
        sh = vecs[v].ids >> (4 * k);
        exp_q.push_back(sh[2:0]);
      end
      tick();
      irq_in = vecs[v].irq;
      tick();
      tick();
      irq_in = 8'h00;
      wait_idle("vec_a", 1'b0);
      repeat (4) tick();
      @(negedge clk);
      check("vec_pending_held", pending, vecs[v].pend_held);
      check("vec_intr_quiet", interrupt_signal, 1'b0);
      for (int k = vecs[v].n1; k < vecs[v].n1 + vecs[v].n2; k++) begin
        sh = vecs[v].ids >> (4 * k);
        exp_q.push_back(sh[2:0]);
      end
      write_mask(8'hFF);
      wait_idle("vec_b", 1'b0);
      check("vec_pending_clear", pending, 8'h00);
    end

    // F1: reset in REQUEST drops interrupt_signal without a clock
    e2_auto = 1'b0;
    exec2   = 1'b0;
    tick();
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    #2;
    check("f_intr_req", interrupt_signal, 1'b1);
    rst = 1'b1;
    #1;
    check("f_intr_async", interrupt_signal, 1'b0);
    tick();
    rst = 1'b0;

    // F2: reset mid-SERVICE (cnt=5), line high at release
    write_mask(8'hF7);
    tick();
    irq_in = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    exec2 = 1'b1;
    tick();
    exec2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      exec2 = 1'b1;
      tick();
      exec2 = 1'b0;
    end
    irq_in = 8'h08;
    @(negedge clk);
    check("f_is_before", in_service, 1'b1);
    check("f_pending_before", pending, 8'h00);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("f_is_async", in_service, 1'b0);
    check("f_id_async", irq_id, 3'd0);
    check("f_pending_async", pending, 8'h00);
    check("f_intr_async2", interrupt_signal, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(3'd3);
    @(negedge clk);
    check("f_pending_release", pending, 8'h00);
    tick();
    @(negedge clk);
    check("f_pending_r1", pending, 8'h08);
    tick();
    @(negedge clk);
    check("f_intr_r2", interrupt_signal, 1'b1);
    check("f_id_r2", irq_id, 3'd3);
    irq_in  = 8'h00;
    e2_auto = 1'b1;
    wait_idle("f", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Source side of the CPU interrupt interface: collects edge-triggered requests from peripheral lines, applies a mask and fixed priority, and drives `interrupt_signal` into the program counter using the PC's take-on-`exec2` protocol. It then tracks the fixed-length interrupt service routine (ISR) by counting `exec2` pulses, and blocks further requests until the routine has retired. It sits beside the PC in the CPU top level and observes the same `exec2` strobe and `pc_halt` flag.

## Interface
- `N_IRQ`, 8, number of request lines; index 0 has the highest priority.
- `ISR_LEN`, 10, number of instructions in the ISR, counted as `exec2` pulses after the take.
- `MASK_RESET`, all ones (`{N_IRQ{1'b1}}`), mask value loaded on reset; 1 = enabled.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `irq_in`  in  N_IRQ  peripheral request levels, synchronous to `clk`.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_data`  in  N_IRQ  new mask value, loaded when `mask_we` = 1.
- `exec2`  in  1  CPU EXEC2 cycle strobe; the PC updates its address on the edge that ends this cycle.
- `pc_halt`  in  1  PC halted flag.
- `interrupt_signal`  out  1  request to the PC.
- `irq_id`  out  clog2(N_IRQ)  index of the request currently dispatched or in service.
- `in_service`  out  1  high while the ISR is executing.
- `pending`  out  N_IRQ  pending-request register, for debug and status.

## Operation
- **Edge detect.** `irq_prev` is a register of `irq_in`, reset to 0. A rising edge on line i (`irq_in[i]` & !`irq_prev[i]`) sets `pending[i]`. Because `irq_prev` resets to 0, a line already high when reset deasserts counts as an edge.
- **Eligibility.** A line is eligible when `pending[i] & mask[i]`. The winner is the lowest eligible index.
- **State machine: IDLE, ARM, REQUEST, SERVICE.**
- **IDLE.**
  - If any line is eligible and `pc_halt` = 0: latch the winner into `irq_id`, clear its pending bit, and go to ARM.
  - Otherwise stay in IDLE.
- **ARM** (exactly 1 cycle).
  - `interrupt_signal` = 1. An `exec2` in this cycle does not count as the take.
  - Next state is REQUEST.
- **REQUEST.**
  - `interrupt_signal` = !`exec2`. It is driven low in the take cycle so the PC does not re-latch the request.
  - On `exec2` = 1, the PC jumps to the ISR on that edge: go to SERVICE with `cnt` = 0.
- **SERVICE.**
  - `in_service` = 1 and `interrupt_signal` = 0.
  - Each `exec2` increments `cnt`. On the `exec2` with `cnt` = ISR_LEN−1, go to IDLE; this is the edge on which the PC returns to its resume address.
  - `cnt` is clog2(ISR_LEN+1) bits wide and never wraps.
- **Halt abort.** If `pc_halt` = 1 in ARM or REQUEST:
  - go to IDLE and re-set `pending[irq_id]`;
  - drive `interrupt_signal` low in that cycle.
- **Halt in SERVICE.** `pc_halt` is ignored in SERVICE. Counting continues only on `exec2`.
- **Pending bits are sticky.** Further edges on a line that is already pending are absorbed. Edges on any line during ARM, REQUEST or SERVICE are latched and dispatched after return to IDLE.
- **Simultaneous events.**
  - An edge on the winning line in the dispatch cycle: set wins, so the bit stays 1 and that line is dispatched again later.
  - `mask_we` in the dispatch cycle: dispatch uses the old mask; the new mask takes effect next cycle.
  - Masking a line that is already pending keeps its pending bit; it is dispatched once unmasked.

## Timing
- **Reset values.**
  - State = IDLE; `interrupt_signal` = 0, `irq_id` = 0, `in_service` = 0.
  - `pending` = 0, `irq_prev` = 0, `cnt` = 0, mask = MASK_RESET.
- **Reset mid-operation** (any state) returns to IDLE immediately and asynchronously; `interrupt_signal` falls without waiting for a clock.
- **Request latency.**
  - Edge on `irq_in` at cycle t: `pending` set at t+1.
  - IDLE→ARM at t+2, so `interrupt_signal` is high in cycle t+2.
- **Take.** The take occurs on the first `exec2` at or after cycle t+3.
- **Back-to-back dispatch.** Minimum gap between two dispatches is ISR_LEN+1 `exec2` pulses plus 1 IDLE cycle.
- **Output timing.** `interrupt_signal` is a registered state decode gated combinationally by `exec2` and `pc_halt`; all other outputs are registered.

## Test plan
- Rise on `irq_in`=8'h04 at cycle 5, with `exec2` every 4th cycle -> `pending`=8'h04 at cycle 6; ARM at cycle 7 with `irq_id`=2; `interrupt_signal` low in the take cycle; `in_service` high for exactly 10 `exec2` pulses, then IDLE.
- Rising edges on `irq_in`=8'h06 in the same cycle -> line 1 dispatched first; line 2 dispatched after ISR return; `pending` reads 8'h04 throughout the first ISR.
- Mask=8'hFE, rise on line 0 -> no request and `pending`=8'h01 held; write mask=8'hFF -> dispatch of `irq_id`=0 two cycles later.
- `pc_halt`=1 asserted during REQUEST -> `interrupt_signal` drops in the same cycle, state returns to IDLE, `pending[id]` is re-set, and no dispatch occurs while `pc_halt`=1.
- `exec2`=1 during ARM -> not counted as the take; SERVICE is entered only on the next `exec2` in REQUEST.
- Assert `reset` mid-SERVICE (`cnt`=5) -> all outputs 0 immediately, mask=8'hFF; with a line high at release, `pending` for that line is set 1 cycle after release.
